// File: rtl/wave_capture_controller_pkg.sv
// wave_capture_controller_pkg: shared FSM state encodings for the wave capture controller
package wave_capture_controller_pkg;
    localparam logic [1:0] S_ARMED  = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
endpackage

// File: rtl/wave_sample_formatter.sv
// wave_sample_formatter: maps a signed sample to the 8-bit display code (positive peaks at the top row)
//  sample     in   SAMPLE_WIDTH  signed two's-complement sample
//  formatted  out  8             display code
module wave_sample_formatter #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [7:0]              formatted
);
    // Offset-binary top byte, inverted so larger values land on smaller row numbers.
    assign formatted = ~{~sample[SAMPLE_WIDTH-1], sample[SAMPLE_WIDTH-2 -: 7]};
endmodule

// File: rtl/wave_capture_controller.sv
// wave_capture_controller: fills the back half of a ping-pong wave RAM on a rising zero crossing
//  clk            in   1             system clock
//  reset          in   1             asynchronous active-high reset
//  sample         in   SAMPLE_WIDTH  signed audio sample
//  new_sample     in   1             sample valid strobe
//  display_idle   in   1             display not scanning; halves may be swapped
//  write_address  out  ADDR_WIDTH+1  {back half, sample index}
//  write_sample   out  8             formatted sample
//  write_enable   out  1             RAM write strobe
//  read_index     out  1             half the display reads
//  capturing      out  1             capture in progress
module wave_capture_controller
    import wave_capture_controller_pkg::*;
#(
    parameter int SAMPLE_WIDTH    = 16,
    parameter int ADDR_WIDTH      = 8,
    parameter int TRIGGER_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    new_sample,
    input  logic                    display_idle,
    output logic [ADDR_WIDTH:0]     write_address,
    output logic [7:0]              write_sample,
    output logic                    write_enable,
    output logic                    read_index,
    output logic                    capturing
);
    localparam int TW = TRIGGER_TIMEOUT > 1 ? $clog2(TRIGGER_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TRIGGER_TIMEOUT > 0 ? TRIGGER_TIMEOUT - 1 : 0);

    logic [1:0]            state, state_nx;
    logic [ADDR_WIDTH-1:0] count;
    logic [TW-1:0]         timeout;
    logic                  prev_msb;
    logic [7:0]            formatted;
    logic                  crossing, forced, trigger, accept, swap;

    wave_sample_formatter #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_fmt (
        .sample    (sample),
        .formatted (formatted)
    );

    assign crossing = prev_msb & ~sample[SAMPLE_WIDTH-1];
    assign forced   = (TRIGGER_TIMEOUT != 0) && (timeout == T_LAST);
    assign trigger  = new_sample && state == S_ARMED && (crossing || forced);
    assign accept   = trigger || (new_sample && state == S_ACTIVE);
    assign swap     = state == S_WAIT && display_idle;

    // count is always 0 in ARMED, so the trigger write lands at index 0 with the same path.
    always_comb begin
        state_nx = trigger ? S_ACTIVE :
                   (state == S_ACTIVE && accept && &count) ? S_WAIT :
                   swap ? S_ARMED : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_ARMED;
            read_index    <= 1'b0;
            count         <= '0;
            prev_msb      <= 1'b0;
            timeout       <= '0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
            capturing     <= 1'b0;
        end else begin
            state        <= state_nx;
            write_enable <= accept;
            capturing    <= state_nx == S_ACTIVE;
            if (new_sample)
                prev_msb <= sample[SAMPLE_WIDTH-1];
            if (accept) begin
                count         <= count + 1'b1;
                write_address <= {~read_index, count};
                write_sample  <= formatted;
            end
            if (swap)
                read_index <= ~read_index;
            if (trigger || swap)
                timeout <= '0;
            else if (state == S_ARMED && new_sample && !(&timeout))
                timeout <= timeout + 1'b1;
        end
    end
endmodule

// File: tb/tb_wave_capture_controller.sv
// tb_wave_capture_controller: directed self-checking bench for wave_capture_controller
module tb_wave_capture_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample = '0;
    logic        new_sample = 1'b0;
    logic        display_idle = 1'b0;
    logic [8:0]  a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic        a_we, b_we, a_ri, b_ri, a_cap, b_cap;
    int          checks = 0;
    int          failures = 0;
    int          swaps;
    logic        last_ri;

    wave_capture_controller u_dut (
        .clk (clk), .reset (reset), .sample (sample), .new_sample (new_sample),
        .display_idle (display_idle), .write_address (a_addr), .write_sample (a_data),
        .write_enable (a_we), .read_index (a_ri), .capturing (a_cap)
    );

    wave_capture_controller #(.TRIGGER_TIMEOUT(4)) u_dut_to (
        .clk (clk), .reset (reset), .sample (sample), .new_sample (new_sample),
        .display_idle (display_idle), .write_address (b_addr), .write_sample (b_data),
        .write_enable (b_we), .read_index (b_ri), .capturing (b_cap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] v);
        sample = v;
        new_sample = 1'b1;
        tick();
        new_sample = 1'b0;
    endtask

    initial begin
        tick();
        check("rst_we", a_we, 0);
        check("rst_addr", a_addr, 0);
        check("rst_data", a_data, 0);
        check("rst_ri", a_ri, 0);
        check("rst_cap", a_cap, 0);
        reset = 1'b0;
        // 1: crossing trigger
        strobe(16'hFFFB);
        check("t1_we_m5", a_we, 0);
        strobe(16'hFFFD);
        check("t1_we_m3", a_we, 0);
        strobe(16'h0002);
        check("t1_we", a_we, 1);
        check("t1_addr", a_addr, 9'h100);
        check("t1_data", a_data, 8'h7F);
        check("t1_cap", a_cap, 1);
        // 2: rest of the frame back-to-back, then WAIT ignores samples
        for (int i = 1; i < 256; i++) begin
            strobe(i == 128 ? 16'h8000 : i == 255 ? 16'h7FFF : 16'(i));
            check("t2_we", a_we, 1);
            check("t2_addr", a_addr, 32'h100 + i);
            check("t2_data", a_data, i == 128 ? 8'hFF : i == 255 ? 8'h00 : 8'h7F);
        end
        check("t2_cap_wait", a_cap, 0);
        strobe(16'h1000);
        check("t2_wait_we0", a_we, 0);
        strobe(16'h1000);
        check("t2_wait_we1", a_we, 0);
        check("t2_ri", a_ri, 0);
        // 3: swap, next frame targets the lower half
        display_idle = 1'b1;
        tick();
        display_idle = 1'b0;
        check("t3_ri", a_ri, 1);
        check("t3_cap", a_cap, 0);
        strobe(16'hFFFF);
        check("t3_we_neg", a_we, 0);
        strobe(16'h0001);
        check("t3_we", a_we, 1);
        check("t3_addr0", a_addr, 9'h000);
        for (int i = 1; i < 256; i++) begin
            strobe(16'h0010);
            check("t3_addr", a_addr, i);
        end
        tick();
        check("t3_we_end", a_we, 0);
        check("t3_cap_end", a_cap, 0);
        // 5: reset mid-ACTIVE at count 37
        display_idle = 1'b1;
        tick();
        display_idle = 1'b0;
        check("t5_ri_swap", a_ri, 0);
        strobe(16'hFFFF);
        strobe(16'h0001);
        check("t5_addr0", a_addr, 9'h100);
        for (int i = 1; i < 37; i++) strobe(16'h0020);
        check("t5_addr36", a_addr, 9'h124);
        check("t5_cap_pre", a_cap, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_we", a_we, 0);
        check("t5_addr", a_addr, 0);
        check("t5_data", a_data, 0);
        check("t5_ri", a_ri, 0);
        check("t5_cap", a_cap, 0);
        tick();
        reset = 1'b0;
        // 6: display_idle held high during the whole capture
        display_idle = 1'b1;
        strobe(16'hFFFF);
        check("t6_ri_armed", a_ri, 0);
        strobe(16'h0001);
        check("t6_we", a_we, 1);
        check("t6_addr0", a_addr, 9'h100);
        swaps = 0;
        last_ri = a_ri;
        for (int i = 1; i < 256; i++) begin
            strobe(16'h0030);
            if (a_ri !== last_ri) swaps++;
            last_ri = a_ri;
        end
        check("t6_addr_last", a_addr, 9'h1FF);
        check("t6_ri_hold", a_ri, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_ri !== last_ri) swaps++;
            last_ri = a_ri;
        end
        check("t6_ri_after", a_ri, 1);
        check("t6_swaps", swaps, 1);
        display_idle = 1'b0;
        // 4: forced trigger with TRIGGER_TIMEOUT=4
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe(16'h0064);
            check("t4_we_early", b_we, 0);
        end
        strobe(16'h0064);
        check("t4_we", b_we, 1);
        check("t4_addr", b_addr, 9'h100);
        check("t4_data", b_data, 8'h7F);
        check("t4_cap", b_cap, 1);
        check("t4_default_no_force", a_we, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
